pe_rs_row_sequencer: RTL and testbench

- Controller that drives one tt_um_PE-style processing element in row-stationary mode to compute a full 1-D, 3-tap convolution over an ifmap row.
- Accepts filter taps, ifmap pixels and upper-row partial sums on valid/ready streams, and sequences the PE's scratchpad loads, start pulses and psum injection.
- Captures each PE result into a one-entry output buffer with backpressure.
- Sits between the array-level scheduler/SRAM readers and each PE column.

---
 rtl/pe_rs_row_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pe_rs_row_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_rs_row_sequencer.sv
// Row-stationary sequencer: feeds one PE 3 taps, a sliding ifmap window and psums; collects row_len-2 results.
// Latency: one PE calculation (start + 5 cycles) per output, plus one cycle per handshake step.
// Backpressure: inputs stall the FSM indefinitely; a full output buffer holds off the next pe_start_o.
module pe_rs_row_sequencer #(
    parameter int MAX_ROW_LEN = 32,
    parameter int CNT_W       = 6,
    parameter int WAIT_MAX    = 15
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             go_i,
    input  logic [CNT_W-1:0] row_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             filt_valid_i,
    output logic             filt_ready_o,
    input  logic [7:0]       filt_data_i,
    input  logic             ifmap_valid_i,
    output logic             ifmap_ready_o,
    input  logic [7:0]       ifmap_data_i,
    input  logic             psum_in_valid_i,
    output logic             psum_in_ready_o,
    input  logic [9:0]       psum_in_data_i,
    output logic [7:0]       pe_filter_o,
    output logic [7:0]       pe_ifmap_o,
    output logic             pe_read_filter_o,
    output logic             pe_read_ifmap_o,
    output logic             pe_mode_o,
    output logic             pe_start_o,
    output logic             pe_end_os_o,
    output logic [9:0]       pe_psum_o,
    input  logic [9:0]       pe_psum_i,
    input  logic             pe_psum_valid_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [9:0]       out_data_o
);
    localparam int WD_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_ROW_LEN);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_LOAD_FILT = 4'd1;
    localparam logic [3:0] S_PRIME    = 4'd2;
    localparam logic [3:0] S_GET_PSUM = 4'd3;
    localparam logic [3:0] S_HOLD     = 4'd4;
    localparam logic [3:0] S_START    = 4'd5;
    localparam logic [3:0] S_WAIT     = 4'd6;
    localparam logic [3:0] S_SLIDE    = 4'd7;
    localparam logic [3:0] S_FINISH   = 4'd8;

    logic [3:0]       state;
    logic [CNT_W-1:0] row_len;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [1:0]       tap_cnt;
    logic [WD_W-1:0]  wd_cnt;
    logic [9:0]       psum_lat;
    logic [9:0]       obuf_dat;
    logic             obuf_vld;
    logic             done_q;
    logic             err_q;

    logic filt_xfer;
    logic ifmap_xfer;
    logic psum_xfer;
    logic len_bad;
    logic last_out;
    logic wd_expire;

    assign filt_ready_o    = (state == S_LOAD_FILT);
    assign ifmap_ready_o   = (state == S_PRIME) || (state == S_SLIDE);
    assign psum_in_ready_o = (state == S_GET_PSUM);

    assign filt_xfer  = filt_valid_i && filt_ready_o;
    assign ifmap_xfer = ifmap_valid_i && ifmap_ready_o;
    assign psum_xfer  = psum_in_valid_i && psum_in_ready_o;

    // Data is only forwarded while its stream can transfer, so the PE bus idles at zero.
    assign pe_filter_o      = filt_ready_o ? filt_data_i : 8'd0;
    assign pe_ifmap_o       = ifmap_ready_o ? ifmap_data_i : 8'd0;
    assign pe_read_filter_o = filt_xfer;
    assign pe_read_ifmap_o  = ifmap_xfer;
    assign pe_mode_o        = 1'b1;
    assign pe_end_os_o      = 1'b0;
    assign pe_start_o       = (state == S_START);
    assign pe_psum_o        = psum_lat;

    assign busy_o      = (state != S_IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign out_valid_o = obuf_vld;
    assign out_data_o  = obuf_dat;

    assign len_bad   = (row_len_i < CNT_W'(3)) || (row_len_i > MAX_LEN);
    assign last_out  = ((out_cnt + CNT_W'(1)) == (row_len - CNT_W'(2)));
    // wd_cnt counts cycles since the start pulse, so expiry lands exactly WAIT_MAX cycles later.
    assign wd_expire = ((wd_cnt + WD_W'(1)) == WD_W'(WAIT_MAX));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= S_IDLE;
            row_len  <= '0;
            pix_cnt  <= '0;
            out_cnt  <= '0;
            tap_cnt  <= '0;
            wd_cnt   <= '0;
            psum_lat <= '0;
            obuf_dat <= '0;
            obuf_vld <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (obuf_vld && out_ready_i) begin
                obuf_vld <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (go_i) begin
                        if (len_bad) begin
                            done_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            row_len <= row_len_i;
                            tap_cnt <= '0;
                            pix_cnt <= '0;
                            out_cnt <= '0;
                            state   <= S_LOAD_FILT;
                        end
                    end
                end
                S_LOAD_FILT: begin
                    if (filt_xfer) begin
                        tap_cnt <= tap_cnt + 2'd1;
                        if (tap_cnt == 2'd2) begin
                            state <= S_PRIME;
                        end
                    end
                end
                S_PRIME: begin
                    if (ifmap_xfer) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        if (pix_cnt == CNT_W'(2)) begin
                            state <= S_GET_PSUM;
                        end
                    end
                end
                S_GET_PSUM: begin
                    if (psum_xfer) begin
                        psum_lat <= psum_in_data_i;
                        state    <= obuf_vld ? S_HOLD : S_START;
                    end
                end
                S_HOLD: begin
                    if (!obuf_vld) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    wd_cnt <= WD_W'(1);
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_psum_valid_i) begin
                        obuf_vld <= 1'b1;
                        obuf_dat <= pe_psum_i;
                        out_cnt  <= out_cnt + CNT_W'(1);
                        state    <= last_out ? S_FINISH : S_SLIDE;
                    end else if (wd_expire) begin
                        done_q <= 1'b1;
                        err_q  <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_SLIDE: begin
                    if (ifmap_xfer) begin
                        pix_cnt <= pix_cnt + CNT_W'(1);
                        state   <= S_GET_PSUM;
                    end
                end
                S_FINISH: begin
                    if (!obuf_vld) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_rs_row_sequencer.sv
// Directed bench for pe_rs_row_sequencer with a behavioural 3-tap PE (result = (sum w*x)>>6 + psum, 5 cycles after start).
`timescale 1ns/1ps
module tb_pe_rs_row_sequencer;
    localparam int WAIT_MAX = 15;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       go_i;
    logic [5:0] row_len_i;
    logic       busy_o, done_o, err_o;
    logic       filt_valid_i, filt_ready_o;
    logic [7:0] filt_data_i;
    logic       ifmap_valid_i, ifmap_ready_o;
    logic [7:0] ifmap_data_i;
    logic       psum_in_valid_i, psum_in_ready_o;
    logic [9:0] psum_in_data_i;
    logic [7:0] pe_filter_o, pe_ifmap_o;
    logic       pe_read_filter_o, pe_read_ifmap_o, pe_mode_o, pe_start_o, pe_end_os_o;
    logic [9:0] pe_psum_o;
    logic [9:0] pe_psum_i;
    logic       pe_psum_valid_i;
    logic       out_valid_o, out_ready_i;
    logic [9:0] out_data_o;

    pe_rs_row_sequencer #(.MAX_ROW_LEN(32), .CNT_W(6), .WAIT_MAX(WAIT_MAX)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .go_i(go_i), .row_len_i(row_len_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .filt_valid_i(filt_valid_i), .filt_ready_o(filt_ready_o), .filt_data_i(filt_data_i),
        .ifmap_valid_i(ifmap_valid_i), .ifmap_ready_o(ifmap_ready_o), .ifmap_data_i(ifmap_data_i),
        .psum_in_valid_i(psum_in_valid_i), .psum_in_ready_o(psum_in_ready_o), .psum_in_data_i(psum_in_data_i),
        .pe_filter_o(pe_filter_o), .pe_ifmap_o(pe_ifmap_o),
        .pe_read_filter_o(pe_read_filter_o), .pe_read_ifmap_o(pe_read_ifmap_o),
        .pe_mode_o(pe_mode_o), .pe_start_o(pe_start_o), .pe_end_os_o(pe_end_os_o),
        .pe_psum_o(pe_psum_o), .pe_psum_i(pe_psum_i), .pe_psum_valid_i(pe_psum_valid_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]       len;
        logic [2:0][7:0]  w;
        logic [4:0][7:0]  x;
        logic [9:0]       p;
        logic [2:0][9:0]  y;
        logic             err;
        logic             gaps;
        logic [5:0]       stall;
    } vec_t;

    vec_t vec [9];
    int errors = 0;
    int checks = 0;
    bit abort  = 0;
    bit pe_dead = 0;

    int cyc = 0, starts = 0, freads = 0, ireads = 0, dones = 0, errs = 0;
    int start_cyc = 0, done_cyc = 0, go_cyc = 0;
    logic done_busy = 1'b0;
    int viol_rd = 0, viol_stab = 0, viol_full = 0, viol_flight = 0;
    bit hold_pending = 0;
    logic [9:0] hold_dat = '0;
    logic [9:0] got [$];

    int tap [3];
    int win [3];
    int pe_cnt = 0;
    logic [9:0] pe_res = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Observation of DUT outputs on the falling edge, mid-cycle.
    always @(negedge clk_i) begin
        cyc++;
        if (pe_start_o) begin
            starts++;
            start_cyc = cyc;
            if (out_valid_o) viol_full++;
        end
        if (pe_read_filter_o) freads++;
        if (pe_read_ifmap_o) ireads++;
        if (pe_read_filter_o != (filt_valid_i && filt_ready_o)) viol_rd++;
        if (pe_read_ifmap_o != (ifmap_valid_i && ifmap_ready_o)) viol_rd++;
        if (done_o) begin
            dones++;
            done_cyc  = cyc;
            done_busy = busy_o;
        end
        if (err_o) errs++;
        if (go_i && !busy_o) go_cyc = cyc;
        if (rstn_i) begin
            if (hold_pending && (!out_valid_o || out_data_o != hold_dat)) viol_stab++;
            hold_pending = out_valid_o && !out_ready_i;
            hold_dat     = out_data_o;
        end else begin
            hold_pending = 0;
        end
        if (out_valid_o && out_ready_i) got.push_back(out_data_o);
    end

    // Behavioural PE: window registers load on read strobes, result 5 cycles after start.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            pe_cnt = 0;
            pe_psum_valid_i = 1'b0;
        end else begin
            pe_psum_valid_i = 1'b0;
            if (pe_read_filter_o) begin
                tap[0] = tap[1]; tap[1] = tap[2]; tap[2] = int'(pe_filter_o);
            end
            if (pe_read_ifmap_o) begin
                win[0] = win[1]; win[1] = win[2]; win[2] = int'(pe_ifmap_o);
            end
            if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0 && !pe_dead) begin
                    pe_psum_valid_i = 1'b1;
                    pe_psum_i = pe_res;
                end
            end
            if (pe_start_o) begin
                if (pe_cnt != 0) viol_flight++;
                pe_cnt = 5;
                pe_res = 10'(((tap[0]*win[0] + tap[1]*win[1] + tap[2]*win[2]) >> 6) + int'(pe_psum_o));
            end
        end
    end

    task automatic set_stream(input int s, input logic vld, input logic [9:0] d);
        case (s)
            0: begin filt_valid_i = vld;    filt_data_i = d[7:0]; end
            1: begin ifmap_valid_i = vld;   ifmap_data_i = d[7:0]; end
            default: begin psum_in_valid_i = vld; psum_in_data_i = d; end
        endcase
    endtask

    function automatic logic stream_ready(input int s);
        case (s)
            0: return filt_ready_o;
            1: return ifmap_ready_o;
            default: return psum_in_ready_o;
        endcase
    endfunction

    task automatic feed(input int s, input vec_t v, input int cnt, input bit gaps);
        logic [9:0] d;
        int t;
        bit ok;
        for (int i = 0; i < cnt && !abort; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    set_stream(s, 1'b0, 10'($urandom));
                    @(posedge clk_i); #1;
                end
            end
            d = (s == 0) ? 10'(v.w[i]) : (s == 1) ? 10'(v.x[i]) : v.p;
            set_stream(s, 1'b1, d);
            ok = 0;
            t  = 0;
            while (!abort && !ok) begin
                @(negedge clk_i);
                if (abort) break;
                if (stream_ready(s)) begin
                    @(posedge clk_i); #1;
                    ok = 1;
                end else if (++t > 500) begin
                    chk($sformatf("stream%0d_timeout", s), t, 0);
                    abort = 1;
                end
            end
        end
        set_stream(s, 1'b0, 10'd0);
    endtask

    task automatic sink(input int n, input int stall);
        int t = 0;
        if (stall > 0) begin
            out_ready_i = 1'b0;
            while (!out_valid_o && t < 500) begin @(negedge clk_i); t++; end
            repeat (stall) @(posedge clk_i);
            #1;
        end
        out_ready_i = 1'b1;
        t = 0;
        while (got.size() < n && t < 1000 && !abort) begin @(negedge clk_i); t++; end
        if (got.size() < n) chk("sink_timeout", got.size(), n);
    endtask

    task automatic clear_counts();
        starts = 0; freads = 0; ireads = 0; dones = 0; errs = 0;
        got.delete();
    endtask

    task automatic pulse_go(input logic [5:0] len);
        @(posedge clk_i); #1;
        row_len_i = len;
        go_i = 1'b1;
        @(posedge clk_i); #1;
        go_i = 1'b0;
    endtask

    task automatic start_job(input vec_t v, input int n_res);
        int t = 0;
        int n_in = v.err ? 0 : int'(v.len) - 2;
        clear_counts();
        pulse_go(v.len);
        fork
            feed(0, v, v.err ? 0 : 3, v.gaps);
            feed(1, v, v.err ? 0 : int'(v.len), v.gaps);
            feed(2, v, n_in, v.gaps);
            sink(n_res, int'(v.stall));
        join
        while (dones == 0 && t < 400) begin @(negedge clk_i); t++; end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic run_row(input int r);
        vec_t v = vec[r];
        int n = v.err ? 0 : int'(v.len) - 2;
        start_job(v, n);
        chk($sformatf("row%0d done_cnt", r), dones, 1);
        chk($sformatf("row%0d err_cnt", r), errs, int'(v.err));
        chk($sformatf("row%0d starts", r), starts, n);
        chk($sformatf("row%0d filt_reads", r), freads, v.err ? 0 : 3);
        chk($sformatf("row%0d ifmap_reads", r), ireads, v.err ? 0 : int'(v.len));
        chk($sformatf("row%0d results", r), got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++)
            chk($sformatf("row%0d y%0d", r, i), int'(got[i]), int'(v.y[i]));
        if (v.err) chk($sformatf("row%0d err_latency", r), done_cyc - go_cyc, 1);
    endtask

    initial begin
        vec[0] = '{len:6'd5, w:{8'd64, 8'd64, 8'd64}, x:{8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, p:10'd0,
                   y:{10'd12, 10'd9, 10'd6}, err:1'b0, gaps:1'b0, stall:6'd0};
        vec[1] = '{len:6'd3, w:{8'd0, 8'd64, 8'd128}, x:{8'd0, 8'd0, 8'd30, 8'd20, 8'd10}, p:10'd5,
                   y:{10'd0, 10'd0, 10'd45}, err:1'b0, gaps:1'b0, stall:6'd0};
        vec[2] = '{len:6'd4, w:{8'd192, 8'd128, 8'd64}, x:{8'd0, 8'd8, 8'd6, 8'd4, 8'd2}, p:10'd1,
                   y:{10'd0, 10'd41, 10'd29}, err:1'b0, gaps:1'b0, stall:6'd0};
        vec[3] = vec[0]; vec[3].stall = 6'd20;
        vec[4] = vec[0]; vec[4].gaps = 1'b1;
        vec[5] = vec[2]; vec[5].gaps = 1'b1;
        vec[6] = '{len:6'd2, w:'0, x:'0, p:'0, y:'0, err:1'b1, gaps:1'b0, stall:6'd0};
        vec[7] = vec[6]; vec[7].len = 6'd33;
        vec[8] = vec[6]; vec[8].len = 6'd0;

        rstn_i = 1'b0; go_i = 1'b0; row_len_i = '0; out_ready_i = 1'b1;
        filt_valid_i = 1'b0; filt_data_i = '0; ifmap_valid_i = 1'b0; ifmap_data_i = '0;
        psum_in_valid_i = 1'b0; psum_in_data_i = '0; pe_psum_i = '0; pe_psum_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("reset_flags", int'({busy_o, done_o, err_o, out_valid_o, pe_start_o, pe_mode_o, filt_ready_o,
                                 ifmap_ready_o, psum_in_ready_o, pe_read_filter_o, pe_read_ifmap_o, pe_end_os_o}), 'h040);
        chk("reset_out_data", int'(out_data_o), 0);
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        for (int r = 0; r < 9; r++) run_row(r);

        // PE never answers: watchdog fires WAIT_MAX cycles after the start pulse.
        pe_dead = 1;
        start_job(vec[1], 0);
        chk("wd err_cnt", errs, 1);
        chk("wd done_cnt", dones, 1);
        chk("wd starts", starts, 1);
        chk("wd latency", done_cyc - start_cyc, WAIT_MAX);
        chk("wd busy_at_done", int'(done_busy), 0);
        chk("wd results", got.size(), 0);
        pe_dead = 0;

        // Asynchronous reset while a result sits unread in the output buffer.
        begin
            int t = 0;
            clear_counts();
            out_ready_i = 1'b0;
            pulse_go(vec[0].len);
            fork
                feed(0, vec[0], 3, 1'b0);
                feed(1, vec[0], 5, 1'b0);
                feed(2, vec[0], 3, 1'b0);
            join_none
            while (!out_valid_o && t < 200) begin @(negedge clk_i); t++; end
            chk("rst_mid out_valid_before", int'(out_valid_o), 1);
            repeat (2) @(negedge clk_i);
            #2 rstn_i = 1'b0;
            #1;
            chk("rst_mid flags", int'({busy_o, done_o, err_o, out_valid_o, pe_start_o, pe_mode_o, filt_ready_o,
                                       ifmap_ready_o, psum_in_ready_o, pe_end_os_o}), 'h010);
            chk("rst_mid out_data", int'(out_data_o), 0);
            chk("rst_mid pe_psum", int'(pe_psum_o), 0);
            abort = 1;
            repeat (3) @(posedge clk_i);
            #1;
            rstn_i = 1'b1;
            abort = 0;
            out_ready_i = 1'b1;
            run_row(0);
        end

        chk("read_without_xfer", viol_rd, 0);
        chk("out_data_stability", viol_stab, 0);
        chk("start_while_full", viol_full, 0);
        chk("start_in_flight", viol_flight, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
